gcd_rr_scheduler: RTL

- Shares one GCD engine among N requesters using round-robin arbitration.
- Latches the winner's operands and pulses the engine START.
- Waits for engine DONE, bounded by a timeout, then returns Y/ERROR to the winner with a one-cycle ACK.
- Sits between client blocks and a single GCD engine instance.

---
 rtl/gcd_rr_scheduler_if.sv | 42 ++++
 rtl/gcd_rr_scheduler.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/gcd_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// gcd_rr_scheduler_if
// Bundles the client-side request/response signals and the engine-side
// start/done signals of the round-robin GCD scheduler.
//   Client side : REQ, A_IN, B_IN (to scheduler); ACK, Y_OUT, ERR_OUT,
//                 TMO_OUT, BUSY, GNT_ID (from scheduler)
//   Engine side : ENG_A, ENG_B, ENG_START (from scheduler);
//                 ENG_Y, ENG_DONE, ENG_ERROR (to scheduler)
// Modports:
//   master - the scheduler itself
//   slave  - the surroundings (clients plus engine)
// ---------------------------------------------------------------------------
interface gcd_rr_scheduler_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   REQ;
  logic [N*W-1:0] A_IN;
  logic [N*W-1:0] B_IN;
  logic [N-1:0]   ACK;
  logic [W-1:0]   Y_OUT;
  logic           ERR_OUT;
  logic           TMO_OUT;
  logic           BUSY;
  logic [2:0]     GNT_ID;
  logic [W-1:0]   ENG_A;
  logic [W-1:0]   ENG_B;
  logic           ENG_START;
  logic [W-1:0]   ENG_Y;
  logic           ENG_DONE;
  logic           ENG_ERROR;

  modport master (
    input  REQ, A_IN, B_IN, ENG_Y, ENG_DONE, ENG_ERROR,
    output ACK, Y_OUT, ERR_OUT, TMO_OUT, BUSY, GNT_ID, ENG_A, ENG_B, ENG_START
  );

  modport slave (
    output REQ, A_IN, B_IN, ENG_Y, ENG_DONE, ENG_ERROR,
    input  ACK, Y_OUT, ERR_OUT, TMO_OUT, BUSY, GNT_ID, ENG_A, ENG_B, ENG_START
  );
endinterface

// File: rtl/gcd_rr_scheduler.sv
// ---------------------------------------------------------------------------
// gcd_rr_scheduler
// Shares one GCD engine among N requesters with round-robin arbitration.
// The winner's operands are latched, the engine is started with a one-cycle
// pulse, and the result (or a timeout abort) is returned to the winner with
// a one-cycle one-hot ACK.
// Ports:
//   CLK   - clock, rising edge
//   RST_N - asynchronous active-low reset; aborts any in-flight service
//   bus   - gcd_rr_scheduler_if.master (client and engine signals)
// Parameters:
//   N (2..8) requesters, W operand width, TIMEOUT (1..255) WAIT cycles
// ---------------------------------------------------------------------------
module gcd_rr_scheduler #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input logic                CLK,
  input logic                RST_N,
  gcd_rr_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   last_q;
  logic [2:0]   gnt_q;
  logic [7:0]   timer_q;
  logic [W-1:0] eng_a_q, eng_b_q, y_q;
  logic         err_q, tmo_q, busy_q;

  // Requests and operands widened to the 8-requester maximum so that a
  // 3-bit index always selects in range.
  logic [7:0]     req_ext;
  logic [8*W-1:0] a_ext, b_ext;
  logic [W-1:0]   a_arr [8];
  logic [W-1:0]   b_arr [8];

  assign req_ext = 8'(bus.REQ);
  assign a_ext   = (8*W)'(bus.A_IN);
  assign b_ext   = (8*W)'(bus.B_IN);

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      a_arr[i] = a_ext[i*W +: W];
      b_arr[i] = b_ext[i*W +: W];
    end
  end

  // Round-robin pick: first requester found scanning last+1, last+2, ...
  // modulo N. The sum never reaches 2N, so one wrap subtraction suffices.
  logic [2:0] pick;
  logic [3:0] idx;
  logic       found;

  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick  = last_q;
    idx   = '0;
    found = 1'b0;
    for (int off = 1; off <= N; off++) begin
      idx = {1'b0, last_q} + 4'(off);
      if (idx >= 4'(N)) idx = idx - 4'(N);
      if (!found && req_ext[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
  end

  wire timeout_hit = (timer_q == 8'(TIMEOUT - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|bus.REQ) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.ENG_DONE || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state alone: no path from REQ to ACK/ENG_START.
  logic [7:0] ack_ext;
  logic       eng_start;

  always_comb begin
    ack_ext   = '0;
    eng_start = 1'b0;
    case (state_q)
      ISSUE:   eng_start = 1'b1;
      RESP:    ack_ext   = 8'd1 << gnt_q;
      default: ;
    endcase
  end

  // Datapath registers: grant, operands, timer, response, pointer.
  // NOTE: every register here has an explicit reset value; there is no
  // storage array, so nothing is left to come up undefined.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_q  <= 3'(N - 1);
      gnt_q   <= '0;
      timer_q <= '0;
      eng_a_q <= '0;
      eng_b_q <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (|bus.REQ) begin
            gnt_q   <= pick;
            eng_a_q <= a_arr[pick];
            eng_b_q <= b_arr[pick];
          end
        end
        ISSUE: timer_q <= '0;
        WAIT: begin
          timer_q <= timer_q + 8'd1;
          // DONE takes precedence over a coincident timeout.
          if (bus.ENG_DONE) begin
            y_q   <= bus.ENG_Y;
            err_q <= bus.ENG_ERROR;
            tmo_q <= 1'b0;
          end else if (timeout_hit) begin
            y_q   <= '0;
            err_q <= 1'b1;
            tmo_q <= 1'b1;
          end
        end
        RESP: last_q <= gnt_q;
        default: ;
      endcase
    end
  end

  assign bus.ACK       = ack_ext[N-1:0];
  assign bus.ENG_START = eng_start;
  assign bus.Y_OUT     = y_q;
  assign bus.ERR_OUT   = err_q;
  assign bus.TMO_OUT   = tmo_q;
  assign bus.BUSY      = busy_q;
  assign bus.GNT_ID    = gnt_q;
  assign bus.ENG_A     = eng_a_q;
  assign bus.ENG_B     = eng_b_q;

endmodule
